// File: rtl/hier_node_pkg.sv
// rtl/hier_node_pkg.sv - shared types and constants for the hierarchy-node controller
package hier_node_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic MODE_SEQ = 1'b0;
  localparam logic MODE_PAR = 1'b1;

  localparam int DEF_NUM_CHILD      = 5;
  localparam int DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/hier_node_timeout_ctr.sv
// rtl/hier_node_timeout_ctr.sv - per-launch wait counter with clear, increment and expiry flag
module hier_node_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Saturates at the last value so a stalled caller never sees a wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = inc_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/hier_node_ctrl.sv
// rtl/hier_node_ctrl.sv - child launch/track sequencer; HIER_NODE_TIMEOUT_EN enables per-launch timeouts
module hier_node_ctrl
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILD      = DEF_NUM_CHILD,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES),
  parameter int IDX_W          = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 mode_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [NUM_CHILD-1:0] child_start_o,
  input  logic [NUM_CHILD-1:0] child_done_i,
  output logic [NUM_CHILD-1:0] done_mask_o,
  output logic [NUM_CHILD-1:0] timeout_mask_o
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHILD - 1);

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [NUM_CHILD-1:0] child_start_q, child_start_d;
  logic [NUM_CHILD-1:0] done_mask_q, done_mask_d;
  logic [NUM_CHILD-1:0] tmo_mask_q, tmo_mask_d;

  logic                 expire;
  logic [NUM_CHILD-1:0] idx_onehot;
  logic [NUM_CHILD-1:0] pending;
  logic [NUM_CHILD-1:0] new_done;
  logic [NUM_CHILD-1:0] new_tmo;
  logic [NUM_CHILD-1:0] resolved;

`ifdef HIER_NODE_TIMEOUT_EN
  hier_node_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q == LAUNCH),
    .inc_i    (state_q == WAIT),
    .expire_o (expire)
  );
`else
  localparam int unused_timeout_cfg = TIMEOUT_CYCLES + TIMEOUT_W;
  assign expire = 1'b0;
`endif

  // A child is pending only while launched and unresolved; in sequential mode that is just idx.
  always_comb begin
    idx_onehot = NUM_CHILD'(1) << idx_q;
    pending    = ~(done_mask_q | tmo_mask_q);
    if (mode_q == MODE_SEQ) begin
      pending = pending & idx_onehot;
    end
    new_done = (state_q == WAIT) ? (child_done_i & pending) : '0;
    new_tmo  = (state_q == WAIT && expire) ? (pending & ~new_done) : '0;
    resolved = done_mask_q | tmo_mask_q | new_done | new_tmo;
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    idx_d         = idx_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    child_start_d = '0;
    done_mask_d   = done_mask_q;
    tmo_mask_d    = tmo_mask_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d        = mode_i;
          idx_d         = '0;
          busy_d        = 1'b1;
          err_d         = 1'b0;
          done_mask_d   = '0;
          tmo_mask_d    = '0;
          child_start_d = (mode_i == MODE_PAR) ? '1 : NUM_CHILD'(1);
          state_d       = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        done_mask_d = done_mask_q | new_done;
        tmo_mask_d  = tmo_mask_q | new_tmo;
        if (|new_tmo) begin
          err_d = 1'b1;
        end
        if (mode_q == MODE_SEQ) begin
          if (|(new_done | new_tmo)) begin
            if (idx_q == IDX_LAST) begin
              done_d  = 1'b1;
              state_d = FINISH;
            end else begin
              idx_d         = idx_q + IDX_W'(1);
              child_start_d = idx_onehot << 1;
              state_d       = LAUNCH;
            end
          end
        end else if (&resolved) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mode_q        <= MODE_SEQ;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      child_start_q <= '0;
      done_mask_q   <= '0;
      tmo_mask_q    <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      idx_q         <= idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      child_start_q <= child_start_d;
      done_mask_q   <= done_mask_d;
      tmo_mask_q    <= tmo_mask_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign child_start_o  = child_start_q;
  assign done_mask_o    = done_mask_q;
  assign timeout_mask_o = tmo_mask_q;

endmodule

// File: tb/tb_hier_node_ctrl.sv
// tb/tb_hier_node_ctrl.sv - self-checking bench for hier_node_ctrl (table vectors, random runs, reset)
module tb_hier_node_ctrl;

  localparam int N  = 5;
  localparam int TC = 16;
`ifdef HIER_NODE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef logic [N-1:0][7:0]  dly_t;
  typedef logic [N-1:0][15:0] st_t;

  typedef struct packed {
    logic         mode;
    dly_t         dly;
    logic         hold;
    logic         spur;
    logic [15:0]  exp_done;
    logic [N-1:0] exp_dm;
    logic [N-1:0] exp_tm;
    logic         exp_err;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic         mode_i;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic [N-1:0] child_start_o;
  logic [N-1:0] child_done_i;
  logic [N-1:0] done_mask_o;
  logic [N-1:0] timeout_mask_o;

  int checks   = 0;
  int failures = 0;

  hier_node_ctrl #(
    .NUM_CHILD      (N),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .mode_i         (mode_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .child_start_o  (child_start_o),
    .child_done_i   (child_done_i),
    .done_mask_o    (done_mask_o),
    .timeout_mask_o (timeout_mask_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit resolves(input int d);
    return (d != 0) && (!TMO_EN || d <= TC);
  endfunction

  // Expected launch cycles, completion cycle and masks, counted from the accepting cycle 0.
  task automatic model(input logic mode, input dly_t dly, output st_t st, output int dcyc,
                       output logic [N-1:0] dm, output logic [N-1:0] tm);
    int t;
    int r;
    int rmax;
    st = '0; dm = '0; tm = '0;
    t = 1; rmax = 0;
    for (int k = 0; k < N; k++) begin
      st[k] = 16'(t);
      if (resolves(int'(dly[k]))) begin
        dm[k] = 1'b1;
        r = t + int'(dly[k]);
      end else begin
        tm[k] = 1'b1;
        r = t + TC;
      end
      if (mode == 1'b0) t = r + 1;
      if (r > rmax) rmax = r;
    end
    dcyc = (mode == 1'b0) ? t : rmax + 1;
  endtask

  // Reactive child emulation: each child answers dly cycles after its own start pulse (0 = silent).
  task automatic run_one(input string tag, input logic mode, input dly_t dly, input bit hold,
                         input bit spur, output st_t st, output int dcyc,
                         output logic [N-1:0] dm, output logic [N-1:0] tm, output logic er);
    int due[N];
    int c;
    int spur_at;
    int ndone;
    bit seen;
    logic [N-1:0] cd;
    for (int k = 0; k < N; k++) due[k] = -1;
    st = '1; dcyc = -1; dm = '0; tm = '0; er = 1'b0;
    c = 0; spur_at = -1; ndone = 0; seen = 1'b0;
    while (c < 400 && !(seen && c == dcyc + 2)) begin
      start_i = (c == 0) || (hold && !seen);
      mode_i  = (c == 0) ? mode : ~mode;
      cd = '0;
      for (int k = 0; k < N; k++) if (due[k] == c) cd[k] = 1'b1;
      if (spur && c == spur_at) cd[0] = 1'b1;
      child_done_i = cd;
      @(negedge clk);
      if (c == 1) chk({tag, " busy_at_1"}, 64'(busy_o), 64'd1);
      for (int k = 0; k < N; k++) begin
        if (child_start_o[k]) begin
          st[k] = 16'(c);
          if (dly[k] != 0) due[k] = c + int'(dly[k]);
          if (k == 0 && spur) spur_at = c + int'(dly[k]) + 2;
        end
      end
      if (done_o) begin
        ndone++;
        if (!seen) begin
          seen = 1'b1; dcyc = c;
          dm = done_mask_o; tm = timeout_mask_o; er = err_o;
        end
      end
      if (seen && c == dcyc + 1) chk({tag, " busy_low_after_done"}, 64'(busy_o), 64'd0);
      @(posedge clk); #1;
      c++;
    end
    start_i = 1'b0;
    child_done_i = '0;
    chk({tag, " run_completed"}, 64'(seen), 64'd1);
    chk({tag, " done_pulses"}, 64'(ndone), 64'd1);
    chk({tag, " mask_hold_idle"}, 64'(done_mask_o), 64'(dm));
  endtask

  task automatic check_run(input string tag, input logic mode, input dly_t dly, input bit hold,
                           input bit spur, input int exp_done, input logic [N-1:0] exp_dm,
                           input logic [N-1:0] exp_tm, input logic exp_err);
    st_t st, mst;
    int dcyc, mdcyc;
    logic [N-1:0] dm, tm, mdm, mtm;
    logic er;
    run_one(tag, mode, dly, hold, spur, st, dcyc, dm, tm, er);
    model(mode, dly, mst, mdcyc, mdm, mtm);
    for (int k = 0; k < N; k++) chk($sformatf("%s start_cyc[%0d]", tag, k), 64'(st[k]), 64'(mst[k]));
    chk({tag, " done_cyc"}, 64'(dcyc), 64'(exp_done));
    chk({tag, " done_mask"}, 64'(dm), 64'(exp_dm));
    chk({tag, " timeout_mask"}, 64'(tm), 64'(exp_tm));
    chk({tag, " err"}, 64'(er), 64'(exp_err));
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    dly_t d;
    st_t mst;
    int mdcyc;
    logic [N-1:0] mdm, mtm;
    logic rmode;

    v = '0; v.mode = 1'b0; v.dly = {8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
    v.exp_done = 16'd21; v.exp_dm = 5'b11111; vecs.push_back(v);
    v = '0; v.mode = 1'b1; v.dly = {8'd4, 8'd5, 8'd3, 8'd9, 8'd2};
    v.exp_done = 16'd11; v.exp_dm = 5'b11111; vecs.push_back(v);
    v = '0; v.mode = 1'b0; v.dly = {8'd2, 8'd2, 8'd2, 8'd2, 8'd2}; v.hold = 1'b1; v.spur = 1'b1;
    v.exp_done = 16'd16; v.exp_dm = 5'b11111; vecs.push_back(v);
    v = '0; v.mode = 1'b1; v.dly = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1}; v.hold = 1'b1; v.spur = 1'b1;
    v.exp_done = 16'd3; v.exp_dm = 5'b11111; vecs.push_back(v);
`ifdef HIER_NODE_TIMEOUT_EN
    v = '0; v.mode = 1'b0; v.dly = {8'd3, 8'd3, 8'd0, 8'd3, 8'd3};
    v.exp_done = 16'd34; v.exp_dm = 5'b11011; v.exp_tm = 5'b00100; v.exp_err = 1'b1; vecs.push_back(v);
    v = '0; v.mode = 1'b0; v.dly = {8'd3, 8'd3, 8'd16, 8'd3, 8'd3};
    v.exp_done = 16'd34; v.exp_dm = 5'b11111; vecs.push_back(v);
    v = '0; v.mode = 1'b1; v.dly = {8'd4, 8'd0, 8'd3, 8'd0, 8'd2};
    v.exp_done = 16'd18; v.exp_dm = 5'b10101; v.exp_tm = 5'b01010; v.exp_err = 1'b1; vecs.push_back(v);
`endif

    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; child_done_i = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset done", 64'(done_o), 64'd0);
    chk("reset err", 64'(err_o), 64'd0);
    chk("reset child_start", 64'(child_start_o), 64'd0);
    chk("reset done_mask", 64'(done_mask_o), 64'd0);
    chk("reset timeout_mask", 64'(timeout_mask_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-WAIT, then late dones while idle must be ignored.
    start_i = 1'b1; mode_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    child_done_i = '1;
    @(negedge clk);
    chk("midrun_reset busy", 64'(busy_o), 64'd0);
    chk("midrun_reset child_start", 64'(child_start_o), 64'd0);
    chk("midrun_reset outs", 64'({done_o, err_o, done_mask_o, timeout_mask_o}), 64'd0);
    @(posedge clk); #1;
    child_done_i = '0;
    @(negedge clk);
    chk("late_done done_mask", 64'(done_mask_o), 64'd0);
    chk("late_done busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      check_run($sformatf("vec%0d", i), vecs[i].mode, vecs[i].dly, vecs[i].hold, vecs[i].spur,
                int'(vecs[i].exp_done), vecs[i].exp_dm, vecs[i].exp_tm, vecs[i].exp_err);
    end

    for (int r = 0; r < 20; r++) begin
      rmode = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) d[k] = TMO_EN ? 8'($urandom_range(0, 20)) : 8'($urandom_range(1, 8));
      model(rmode, d, mst, mdcyc, mdm, mtm);
      check_run($sformatf("rnd%0d", r), rmode, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                mdcyc, mdm, mtm, |mtm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hier_node_ctrl.md
# hier_node_ctrl

Parametrised hierarchy-node controller that launches and tracks a configurable number of child sub-blocks. It replaces the fixed five-child structural node with an active sequencer. On an upstream start it pulses child starts sequentially or all at once, collects per-child done handshakes, optionally flags children that time out, and reports completion upstream. One instance sits at each non-leaf node of the generated module tree.

## Interface
- NUM_CHILD, 5, number of child sub-blocks; range 1..64
- TIMEOUT_CYCLES, 256, WAIT cycles allowed per launch before timeout; must be ≥2
- TIMEOUT_W, $clog2(TIMEOUT_CYCLES), width of the timeout counter
- IDX_W, $clog2(NUM_CHILD) (min 1), width of the sequential child index
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start_i  in  1  start request; accepted only in IDLE
- mode_i  in  1  0 = sequential, 1 = parallel; sampled on the cycle start_i is accepted
- busy_o  out  1  high from the cycle after acceptance through FINISH
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky: at least one child timed out this run
- child_start_o  out  NUM_CHILD  one-cycle start pulses, one bit per child
- child_done_i  in  NUM_CHILD  child completion pulses
- done_mask_o  out  NUM_CHILD  children that completed this run
- timeout_mask_o  out  NUM_CHILD  children that timed out this run

## Operation
- Reset (rst_n low at a clock edge) puts the block in IDLE and drives every output to 0; all masks, index and counter are cleared. Reset mid-run abandons the run; late child dones are ignored.
- States: IDLE, LAUNCH, WAIT, FINISH. Encoding is registered and all outputs are registered.
- IDLE: start_i=1 latches mode_i, clears done_mask_o, timeout_mask_o and err_o, sets idx=0 and moves to LAUNCH. start_i in any other state is ignored.
- LAUNCH, sequential: child_start_o[idx]=1 for one cycle. LAUNCH, parallel: child_start_o = all ones for one cycle. Both clear the timeout counter and move to WAIT.
- WAIT, sequential: child_done_i[idx] sets done_mask_o[idx]. If idx==NUM_CHILD-1, go to FINISH; otherwise idx++ and go to LAUNCH.
- WAIT, parallel: each asserted child_done_i bit sets its done_mask_o bit. Go to FINISH when every bit is resolved (done_mask_o | timeout_mask_o all ones, counting the current cycle's dones).
- Dones from children not currently pending (not launched, already done, or timed out) are ignored. child_done_i is ignored outside WAIT.
- FINISH: done_o=1 for one cycle, then go to IDLE. Masks and err_o hold until the next accepted start.
- Timeout (with macro): the counter increments every WAIT cycle. When it equals TIMEOUT_CYCLES-1, every pending child gets its timeout_mask_o bit set and err_o is set. The FSM then advances as if those children were done. A done arriving in the expiry cycle wins: the done bit is set and the timeout bit is not.

## Timing
- start_i accepted at cycle 0: busy_o=1 and first child_start_o pulse at cycle 1.
- Sequential: child_start_o[k] at t and child_done_i[k] at t+d (d≥1) give child_start_o[k+1] at t+d+1.
- The last resolving done at T gives done_o=1 at T+1, and busy_o=0 plus IDLE at T+2. A new start is accepted at T+2 at the earliest.
- Timeout expiry happens TIMEOUT_CYCLES cycles after the launch pulse.

## Configuration
- HIER_NODE_TIMEOUT_EN defined: timeout counter and behaviour as above.
- HIER_NODE_TIMEOUT_EN undefined: no counter; WAIT lasts until the child dones arrive; timeout_mask_o and err_o are tied to 0; TIMEOUT_CYCLES and TIMEOUT_W are unused.

## Structure
- Package hier_node_pkg holds the state enum typedef (IDLE/LAUNCH/WAIT/FINISH), the mode constants MODE_SEQ=1'b0 and MODE_PAR=1'b1, and the default parameter constants.
- One sub-module, hier_node_timeout_ctr, holds the clear/increment/expire counter. It is instantiated only under HIER_NODE_TIMEOUT_EN.

## Test plan
- Sequential, NUM_CHILD=5, each child done 3 cycles after its start, start at cycle 0 -> child_start pulses at 1, 5, 9, 13, 17; done_o at 21; busy_o low at 22; done_mask_o=5'b11111.
- Parallel, start at 0, dones for children 0..4 at cycles 3, 10, 4, 6, 5 -> child_start_o=5'b11111 at 1; done_o at 11; done_mask_o=5'b11111.
- Timeout, TIMEOUT_CYCLES=16, sequential, child 2 silent with launch at t -> timeout_mask_o=5'b00100 and err_o=1 at t+17; child_start_o[3] at t+17; done_mask_o=5'b11011 at done_o.
- Done in expiry cycle t+16 -> done_mask_o bit set, timeout_mask_o bit clear, err_o=0.
- Spurious inputs: start_i held high during a run, plus a repeated done for child 0 -> no restart; masks unchanged; exactly one done_o.
- rst_n low for one cycle during WAIT -> next cycle all outputs 0 and IDLE; a following start runs cleanly from child 0.
